ray_perf_monitor: RTL and testbench

Synthesizable, parametrised performance monitor for the ray pipeline. It replaces bench-only stall and latency bookkeeping with on-chip counters that can be read out over a simple register port. It sits beside the ray pipeline and is fed by:
- per-interface stall/event strobes;
- ray-ID issue/retire strobes at the shader rayID FIFO.

Outputs are saturating event counters, completed-ray count, min/max/summed ray latency, and sticky protocol-error flags.

---
 rtl/ray_perf_monitor.sv | 174 +++++++++++++++++
 tb/tb_ray_perf_monitor.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_perf_monitor.sv
// ray_perf_monitor: saturating event counters and ray-latency statistics behind a register read port.
// Define RAY_PERF_LAT_EN to build the ray-ID table, latency pipeline, outstanding count and error flags.
module ray_perf_monitor #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ID_W   = 9,
  parameter int unsigned TS_W   = 24,
  parameter int unsigned SUM_W  = 48,
  localparam int unsigned RA_W  = $clog2(NUM_CH + 4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ch_event,
  input  logic              issue_valid,
  input  logic [ID_W-1:0]   issue_id,
  input  logic              retire_valid,
  input  logic [ID_W-1:0]   retire_id,
  input  logic              rd_req,
  input  logic [RA_W-1:0]   rd_addr,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [SUM_W-1:0]  lat_sum,
  output logic              err_dup,
  output logic              err_orphan
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0]  ts;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] lat_min;
  logic [CNT_W-1:0] lat_max;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] rd_mux_c;

  // Free-running timestamp, independent of enable and clear
  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + TS_W'(1);
  end

  // Channel counters; clear wins over a same-cycle event
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rst || clear)
        cnt[i] <= '0;
      else if (enable && ch_event[i] && (cnt[i] != CNT_MAX))
        cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

`ifdef RAY_PERF_LAT_EN
  localparam int unsigned DEPTH = 2 ** ID_W;
  localparam int unsigned XW    = (TS_W > CNT_W) ? TS_W : CNT_W;

  logic [TS_W-1:0]  ts_mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic             retire_ok_c;
  logic             issue_new_c;
  logic             issue_dup_c;
  logic             s1_vld;
  logic [TS_W-1:0]  s1_ent;
  logic [TS_W-1:0]  s1_ts;
  logic             s2_vld;
  logic [TS_W-1:0]  s2_lat;
  logic [CNT_W-1:0] lat_cnt_c;
  logic [SUM_W:0]   sum_c;
  logic [SUM_W-1:0] lat_sum_q;
  logic             err_dup_q;
  logic             err_orphan_q;

  // A retire of the issued ID in the same cycle frees the slot, so that issue is not a duplicate
  assign retire_ok_c = retire_valid && vld[retire_id];
  assign issue_dup_c = issue_valid && vld[issue_id] && !(retire_ok_c && (retire_id == issue_id));
  assign issue_new_c = issue_valid && !issue_dup_c;

  // Read happens in the retire cycle and returns the pre-write entry, so a previous-cycle
  // issue is already visible and a same-cycle re-issue does not disturb the measurement
  always_ff @(posedge clk) begin
    if (issue_valid) ts_mem[issue_id] <= ts;
    s1_ent <= ts_mem[retire_id];
    s1_ts  <= ts;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld         <= '0;
      outstanding <= '0;
      s1_vld      <= 1'b0;
      s2_vld      <= 1'b0;
      s2_lat      <= '0;
    end else begin
      if (retire_ok_c) vld[retire_id] <= 1'b0;
      if (issue_valid) vld[issue_id]  <= 1'b1;
      if (issue_new_c && !retire_ok_c)
        outstanding <= outstanding + CNT_W'(1);
      else if (retire_ok_c && !issue_new_c)
        outstanding <= outstanding - CNT_W'(1);
      s1_vld <= retire_ok_c;
      s2_vld <= s1_vld;
      s2_lat <= s1_ts - s1_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_dup_q    <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      if (issue_dup_c)                     err_dup_q    <= 1'b1;
      if (retire_valid && !vld[retire_id]) err_orphan_q <= 1'b1;
    end
  end

  assign lat_cnt_c = (XW'(s2_lat) > XW'(CNT_MAX)) ? CNT_MAX : CNT_W'(s2_lat);
  assign sum_c     = {1'b0, lat_sum_q} + (SUM_W+1)'(s2_lat);

  // Statistics update; a same-cycle clear discards it
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      retired   <= '0;
      lat_min   <= CNT_MAX;
      lat_max   <= '0;
      lat_sum_q <= '0;
    end else if (enable && s2_vld) begin
      if (retired != CNT_MAX)  retired <= retired + CNT_W'(1);
      if (lat_cnt_c < lat_min) lat_min <= lat_cnt_c;
      if (lat_cnt_c > lat_max) lat_max <= lat_cnt_c;
      lat_sum_q <= sum_c[SUM_W] ? '1 : sum_c[SUM_W-1:0];
    end
  end

  assign lat_sum    = lat_sum_q;
  assign err_dup    = err_dup_q;
  assign err_orphan = err_orphan_q;
`else
  logic unused_lat;

  assign unused_lat  = ^{issue_valid, issue_id, retire_valid, retire_id, ts};
  assign retired     = '0;
  assign lat_min     = '0;
  assign lat_max     = '0;
  assign outstanding = '0;
  assign lat_sum     = '0;
  assign err_dup     = 1'b0;
  assign err_orphan  = 1'b0;
`endif

  always_comb begin
    rd_mux_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(rd_addr) == i) rd_mux_c = cnt[i];
    end
    if (32'(rd_addr) == NUM_CH)         rd_mux_c = retired;
    if (32'(rd_addr) == NUM_CH + 32'd1) rd_mux_c = lat_min;
    if (32'(rd_addr) == NUM_CH + 32'd2) rd_mux_c = lat_max;
    if (32'(rd_addr) == NUM_CH + 32'd3) rd_mux_c = outstanding;
  end

  // Read port: one-cycle latency, data holds while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_mux_c;
    end
  end

endmodule

// File: tb/tb_ray_perf_monitor.sv
// tb_ray_perf_monitor: directed and random traffic against a queue/array reference model;
// read responses are checked by a separate monitor against a scoreboard.
module tb_ray_perf_monitor;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned TS_W   = 8;
  localparam int unsigned SUM_W  = 16;
  localparam int unsigned RA_W   = $clog2(NUM_CH + 4);
  localparam int NID  = 16;
  localparam int CMAX = 255;
  localparam int SMAX = 65535;
  localparam int TMOD = 256;
`ifdef RAY_PERF_LAT_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              clear = 1'b0;
  logic [NUM_CH-1:0] ch_event = '0;
  logic              issue_valid = 1'b0;
  logic [ID_W-1:0]   issue_id = '0;
  logic              retire_valid = 1'b0;
  logic [ID_W-1:0]   retire_id = '0;
  logic              rd_req = 1'b0;
  logic [RA_W-1:0]   rd_addr = '0;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [SUM_W-1:0]  lat_sum;
  logic              err_dup;
  logic              err_orphan;

  ray_perf_monitor #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .ID_W(ID_W), .TS_W(TS_W), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .ch_event(ch_event),
    .issue_valid(issue_valid), .issue_id(issue_id),
    .retire_valid(retire_valid), .retire_id(retire_id),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .lat_sum(lat_sum), .err_dup(err_dup), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int lat; } pend_t;
  typedef struct { int addr; int val; } rd_t;

  // Reference model state (written only by the driver process)
  int    m_cnt [NUM_CH];
  int    m_ret, m_min, m_max, m_out, m_sum, m_ts, m_cyc;
  bit    m_dup, m_orph;
  bit    m_live [NID];
  int    m_its [NID];
  pend_t pend [$];
  rd_t   sb [$];
  bit    chk_en = 1'b0;
  bit    end_req = 1'b0;

  // Monitor state
  int rd_idx = 0;
  int last_rd = 0;
  int n_chk = 0;
  int n_pass = 0;

  function automatic void model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    foreach (m_live[i]) m_live[i] = 1'b0;
    m_ret = 0; m_min = CMAX; m_max = 0; m_out = 0; m_sum = 0;
    m_dup = 1'b0; m_orph = 1'b0; m_ts = 0;
    pend.delete();
  endfunction

  function automatic int model_read(int a);
    if (a < NUM_CH) return m_cnt[a];
    if (!LAT_EN) return 0;
    case (a - NUM_CH)
      0: return m_ret;
      1: return m_min;
      2: return m_max;
      3: return m_out;
      default: return 0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs the bench is driving
  function automatic void model_edge();
    bit dup_n, orph_n;
    int r, k, lat;
    pend_t p;
    dup_n = 1'b0; orph_n = 1'b0;
    m_cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    if (rd_req) sb.push_back('{int'(rd_addr), model_read(int'(rd_addr))});
    while (pend.size() > 0 && pend[0].due <= m_cyc) begin
      p = pend.pop_front();
      if (enable && !clear) begin
        m_ret = (m_ret + 1 > CMAX) ? CMAX : m_ret + 1;
        if (p.lat < m_min) m_min = p.lat;
        if (p.lat > m_max) m_max = p.lat;
        m_sum = (m_sum + p.lat > SMAX) ? SMAX : m_sum + p.lat;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (clear) m_cnt[i] = 0;
      else if (enable && ch_event[i] && m_cnt[i] < CMAX) m_cnt[i]++;
    end
    if (LAT_EN) begin
      if (retire_valid) begin
        r = int'(retire_id);
        if (m_live[r]) begin
          lat = (m_ts - m_its[r] + TMOD) % TMOD;
          pend.push_back('{m_cyc + 2, lat});
          m_live[r] = 1'b0;
          m_out--;
        end else orph_n = 1'b1;
      end
      if (issue_valid) begin
        k = int'(issue_id);
        if (m_live[k]) dup_n = 1'b1;
        else m_out++;
        m_live[k] = 1'b1;
        m_its[k] = m_ts;
      end
    end
    if (clear) begin
      m_ret = 0; m_min = CMAX; m_max = 0; m_sum = 0;
      m_dup = 1'b0; m_orph = 1'b0;
    end else begin
      m_dup  = m_dup | dup_n;
      m_orph = m_orph | orph_n;
    end
    m_ts = (m_ts + 1) % TMOD;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    clear = 1'b0; ch_event = '0; issue_valid = 1'b0; retire_valid = 1'b0; rd_req = 1'b0;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic rd(int a);
    rd_req = 1'b1; rd_addr = RA_W'(a);
    tick();
  endtask

  task automatic rd_stats();
    for (int a = NUM_CH; a < 16; a++) rd(a);
  endtask

  task automatic issue(int id);
    issue_valid = 1'b1; issue_id = ID_W'(id);
    tick();
  endtask

  task automatic retire(int id);
    retire_valid = 1'b1; retire_id = ID_W'(id);
    tick();
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic wait_ts(int t);
    for (int k = 0; k < 300 && m_ts != t; k++) tick();
  endtask

  // Driver: directed scenarios then randomized traffic
  initial begin
    int lst [$];
    int id;
    model_reset();
    m_cyc = 0;
    do_reset(3);
    chk_en = 1'b1;
    for (int a = 0; a < 16; a++) rd(a);
    enable = 1'b1;

    repeat (100) begin ch_event = NUM_CH'(8); tick(); end
    rd(3); rd(0);
    clear = 1'b1; tick();
    repeat (300) begin ch_event = NUM_CH'(8); tick(); end
    rd(3);
    idle(2);
    ch_event = NUM_CH'(8); clear = 1'b1; tick();
    rd(3); idle(1);

    wait_ts(10); issue(5);
    wait_ts(47); retire(5);
    idle(3); rd_stats();

    issue(7); retire(7); idle(3); rd_stats();
    issue(7); idle(2);
    issue_valid = 1'b1; issue_id = ID_W'(7); retire_valid = 1'b1; retire_id = ID_W'(7); tick();
    idle(3); rd_stats();
    retire(7); idle(3); rd_stats();

    retire(12); idle(1); rd(NUM_CH);
    issue(3); issue(3); idle(1); rd(NUM_CH + 3);
    clear = 1'b1; tick(); idle(1);
    retire(3); idle(3);

    wait_ts(250); issue(2);
    wait_ts(4); retire(2);
    idle(3); rd_stats();

    enable = 1'b0;
    issue(9); idle(1); retire(9); idle(4); rd_stats();
    enable = 1'b1;

    issue(4); idle(2); retire(4);
    do_reset(1);
    enable = 1'b1;
    idle(3); rd_stats();

    for (int c = 0; c < 2500; c++) begin
      if (c == 1200) begin idle(1); do_reset(1); end
      enable = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 63) == 0);
      ch_event = NUM_CH'($urandom);
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_id = ID_W'($urandom);
      lst.delete();
      for (int i = 0; i < NID; i++) if (m_live[i]) lst.push_back(i);
      if (lst.size() > 0 && $urandom_range(0, 4) != 0)
        id = lst[$urandom_range(0, lst.size() - 1)];
      else
        id = int'($urandom_range(0, NID - 1));
      retire_valid = ($urandom_range(0, 2) == 0);
      retire_id = ID_W'(id);
      rd_req = ($urandom_range(0, 1) == 1);
      rd_addr = RA_W'($urandom);
      tick();
    end

    enable = 1'b1;
    idle(3);
    for (int a = 0; a < 16; a++) rd(a);
    for (int k = 0; k < 20 && rd_idx < sb.size(); k++) tick();
    end_req = 1'b1;
    forever @(negedge clk);
  end

  function automatic void check(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endfunction

  // Monitor: registered outputs sampled on the falling edge
  always @(negedge clk) begin
    if (end_req) begin
      check("drain", rd_idx, sb.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end else if (rst) begin
      last_rd = 0;
    end else if (chk_en) begin
      check("lat_sum", int'(lat_sum), m_sum);
      check("err_dup", int'(err_dup), int'(m_dup));
      check("err_orphan", int'(err_orphan), int'(m_orph));
      if (rd_valid) begin
        if (rd_idx >= sb.size()) begin
          check("rd_spurious", 1, 0);
        end else begin
          check($sformatf("rd_addr%0d", sb[rd_idx].addr), int'(rd_data), sb[rd_idx].val);
          last_rd = sb[rd_idx].val;
          rd_idx++;
        end
      end else begin
        check("rd_hold", int'(rd_data), last_rd);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
